// File: rtl/joypad_reader_if.sv
// rtl/joypad_reader_if.sv - NES-side, pad-side and poll control signals of the joypad reader
interface joypad_reader_if #(
  parameter int NUM_PADS = 2,
  parameter int BITS     = 8
) ();
  logic                     ce;
  logic                     mode;
  logic                     poll_start;
  logic                     nes_strobe;
  logic [NUM_PADS-1:0]      nes_clock;
  logic [NUM_PADS-1:0]      joy_data;
  logic                     joy_strobe;
  logic [NUM_PADS-1:0]      joy_clock;
  logic [NUM_PADS-1:0]      nes_data;
  logic [NUM_PADS*BITS-1:0] buttons;
  logic                     valid;
  logic                     busy;

  modport master (
    output ce, mode, poll_start, nes_strobe, nes_clock, joy_data,
    input  joy_strobe, joy_clock, nes_data, buttons, valid, busy
  );

  modport slave (
    input  ce, mode, poll_start, nes_strobe, nes_clock, joy_data,
    output joy_strobe, joy_clock, nes_data, buttons, valid, busy
  );
endinterface

// File: rtl/joypad_reader.sv
// rtl/joypad_reader.sv - NES joypad passthrough / autonomous poller with shift-register emulation
module joypad_reader #(
  parameter int NUM_PADS    = 2,
  parameter int BITS        = 8,
  parameter int CLK_DIV     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  joypad_reader_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(BITS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BITS - 1);

  typedef enum logic [2:0] {IDLE, STROBE, CLK_HI, CLK_LO, DONE} state_t;

  state_t                            state_q, state_d;
  logic [PW-1:0]                     phase_q, phase_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic                              mode_q, mode_d;
  logic                              busy_q, busy_d;
  logic                              valid_q, valid_d;
  logic                              jstrobe_q, jstrobe_d;
  logic                              jclock_q, jclock_d;
  logic [SYNC_STAGES*NUM_PADS-1:0]   sync_q, sync_d;
  logic [NUM_PADS-1:0]               sync_data;
  logic                              cap;
  logic [IW-1:0]                     cap_idx;
  logic                              phase_last;

  assign sync_d     = {sync_q[(SYNC_STAGES-1)*NUM_PADS-1:0], bus.joy_data};
  assign sync_data  = ~sync_q[SYNC_STAGES*NUM_PADS-1 -: NUM_PADS];
  assign phase_last = (phase_q == PHASE_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    cap_idx = '0;
    mode_d  = (state_q == IDLE) ? bus.mode : mode_q;

    case (state_q)
      IDLE: begin
        if (bus.ce && mode_q && bus.poll_start) begin
          state_d = STROBE;
          phase_d = '0;
          idx_d   = IW'(1);
        end
      end
      STROBE, CLK_HI, CLK_LO: begin
        if (bus.ce) begin
          phase_d = phase_last ? '0 : phase_q + 1'b1;
          if (phase_last) begin
            case (state_q)
              STROBE: begin
                cap     = 1'b1;
                state_d = CLK_HI;
              end
              CLK_HI: begin
                cap     = 1'b1;
                cap_idx = idx_q;
                state_d = CLK_LO;
              end
              default: begin
                if (idx_q < IDX_LAST) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = CLK_HI;
                end else begin
                  state_d = DONE;
                end
              end
            endcase
          end
        end
      end
      // DONE lasts one clock regardless of ce so valid is a single-clock pulse
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == STROBE) || (state_d == CLK_HI) || (state_d == CLK_LO);
    jstrobe_d = (state_d == STROBE);
    jclock_d  = (state_d == CLK_HI);
    valid_d   = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      jstrobe_q <= 1'b0;
      jclock_q  <= 1'b0;
      sync_q    <= '1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      jstrobe_q <= jstrobe_d;
      jclock_q  <= jclock_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.joy_strobe = mode_q ? jstrobe_q : bus.nes_strobe;
  assign bus.joy_clock  = mode_q ? {NUM_PADS{jclock_q}} : bus.nes_clock;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [BITS-1:0] shadow_q, shadow_d;
    logic [BITS-1:0] buttons_q, buttons_d;
    logic [BITS-1:0] emu_q, emu_d;
    logic [BITS-1:0] mask;
    logic            pt_q, pt_d;
    logic            nclk_q, nclk_d;
    logic            fall;

    assign fall   = nclk_q & ~bus.nes_clock[p];
    assign nclk_d = bus.nes_clock[p];
    assign mask   = {{(BITS-1){1'b0}}, 1'b1} << cap_idx;

    always_comb begin
      shadow_d = shadow_q;
      if (cap) shadow_d = (shadow_q & ~mask) | (sync_data[p] ? mask : '0);
      buttons_d = valid_d ? shadow_d : buttons_q;

      pt_d = pt_q;
      if (bus.nes_strobe || fall) pt_d = sync_data[p];

      // strobe loads buttons_d so a poll finishing this clock is seen immediately
      emu_d = emu_q;
      if (bus.nes_strobe)  emu_d = buttons_d;
      else if (fall)       emu_d = {1'b1, emu_q[BITS-1:1]};
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        shadow_q  <= '0;
        buttons_q <= '0;
        emu_q     <= '0;
        pt_q      <= 1'b0;
        nclk_q    <= 1'b0;
      end else begin
        shadow_q  <= shadow_d;
        buttons_q <= buttons_d;
        emu_q     <= emu_d;
        pt_q      <= pt_d;
        nclk_q    <= nclk_d;
      end
    end

    assign bus.buttons[p*BITS +: BITS] = buttons_q;
    assign bus.nes_data[p]             = mode_q ? emu_q[0] : pt_q;
  end
endmodule

// File: tb/tb_joypad_reader.sv
// tb/tb_joypad_reader.sv - scoreboard bench for joypad_reader with 4021 pad models
module tb_joypad_reader;
  localparam int NP   = 2;
  localparam int BITS = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  joypad_reader_if #(.NUM_PADS(NP), .BITS(BITS)) bus ();

  joypad_reader #(.NUM_PADS(NP), .BITS(BITS), .CLK_DIV(6), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ce: one tick in four; stall freezes the divider so the schedule shifts exactly
  logic stall = 1'b0;
  int   div   = 0;
  always @(posedge clock) begin
    #2;
    if (stall) begin
      bus.ce = 1'b0;
    end else begin
      bus.ce = (div == 3);
      div    = (div + 1) % 4;
    end
  end

  // 4021-style pads: parallel load while strobe high, shift on rising pad clock
  logic [7:0] pad_val0, pad_val1, sr0, sr1;
  logic       prevc0, prevc1;
  logic       pt_drive, pt_val;
  always @(posedge clock) begin
    #3;
    if (bus.joy_strobe) begin
      sr0 = pad_val0;
      sr1 = pad_val1;
    end else begin
      if (bus.joy_clock[0] && !prevc0) sr0 = {1'b1, sr0[7:1]};
      if (bus.joy_clock[1] && !prevc1) sr1 = {1'b1, sr1[7:1]};
    end
    prevc0 = bus.joy_clock[0];
    prevc1 = bus.joy_clock[1];
    bus.joy_data = {sr1[0], pt_drive ? pt_val : sr0[0]};
  end

  logic [15:0] exp_q[$];
  logic        pt_exp[$];
  int          valid_cnt = 0;
  int          busy_run  = 0;
  int          last_len  = 0;
  logic        busy_prev = 1'b0;

  always @(posedge clock) begin
    #1;
    if (bus.valid) begin
      valid_cnt++;
      check("valid_busy_low", 32'(bus.busy), 32'd0);
      check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("buttons", 32'(bus.buttons), 32'(exp_q.pop_front()));
    end
    if (bus.busy) begin
      busy_run++;
    end else if (busy_prev) begin
      last_len = busy_run;
      busy_run = 0;
    end
    busy_prev = bus.busy;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clock);
      if (bus.ce) k++;
    end
    @(negedge clock);
  endtask

  task automatic start_poll();
    int k;
    k = 0;
    bus.poll_start = 1'b1;
    while (!bus.busy && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("poll_started", 32'(bus.busy), 32'd1);
    bus.poll_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (bus.busy && k < limit) begin
      @(negedge clock);
      k++;
    end
    check("poll_ends", 32'(bus.busy), 32'd0);
  endtask

  logic pt_prev;
  task automatic pt_step(input logic v, input logic via_strobe);
    pt_exp.push_back(~v);
    if (via_strobe) begin
      bus.nes_strobe = 1'b1;
      pt_val = v;
      cycles(3);
      check("pt_latency", 32'(bus.nes_data[0]), 32'(pt_prev));
      check("pt_mirror_strobe", 32'(bus.joy_strobe), 32'(bus.nes_strobe));
      cycles(1);
      check("pt_strobe_load", 32'(bus.nes_data[0]), 32'(pt_exp.pop_front()));
      bus.nes_strobe = 1'b0;
    end else begin
      pt_val = v;
      cycles(5);
      check("pt_hold", 32'(bus.nes_data[0]), 32'(pt_prev));
      bus.nes_clock[0] = 1'b1;
      cycles(1);
      check("pt_mirror_clock", 32'(bus.joy_clock), 32'(bus.nes_clock));
      bus.nes_clock[0] = 1'b0;
      cycles(1);
      check("pt_fall_load", 32'(bus.nes_data[0]), 32'(pt_exp.pop_front()));
    end
    pt_prev = ~v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         vcnt0;
    logic       held;
    int         k;
    logic [7:0] e;

    bus.mode       = 1'b0;
    bus.poll_start = 1'b0;
    bus.nes_strobe = 1'b0;
    bus.nes_clock  = '0;
    pad_val0 = 8'h5A;
    pad_val1 = 8'h3C;
    sr0 = 8'hFF;
    sr1 = 8'hFF;
    prevc0 = 1'b0;
    prevc1 = 1'b0;
    pt_drive = 1'b1;
    pt_val   = 1'b1;
    pt_prev  = 1'b0;

    #1 reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_buttons", 32'(bus.buttons), 32'd0);
    check("rst_nes_data", 32'(bus.nes_data), 32'd0);
    bus.nes_strobe = 1'b1;
    bus.nes_clock  = 2'b10;
    #1;
    check("rst_strobe_follow", 32'(bus.joy_strobe), 32'd1);
    check("rst_clock_follow", 32'(bus.joy_clock), 32'h2);
    bus.nes_strobe = 1'b0;
    bus.nes_clock  = '0;
    cycles(3);
    reset = 1'b0;
    cycles(2);

    pt_step(1'b0, 1'b1);
    pt_step(1'b1, 1'b0);
    pt_step(1'b1, 1'b0);
    pt_step(1'b0, 1'b1);

    bus.poll_start = 1'b1;
    cycles(30);
    check("pt_ignores_poll", 32'(bus.busy), 32'd0);
    check("pt_buttons_hold", 32'(bus.buttons), 32'd0);
    bus.poll_start = 1'b0;

    pt_drive = 1'b0;
    bus.mode = 1'b1;
    cycles(2);
    exp_q.push_back({~pad_val1, ~pad_val0});
    vcnt0 = valid_cnt;
    start_poll();
    check("auto_joy_strobe", 32'(bus.joy_strobe), 32'd1);
    wait_idle(1000);
    check("poll_len", 32'(last_len), 32'd360);
    check("valid_once", 32'(valid_cnt - vcnt0), 32'd1);
    check("auto_idle_strobe", 32'(bus.joy_strobe), 32'd0);
    check("auto_idle_clock", 32'(bus.joy_clock), 32'd0);

    e = ~pad_val0;
    for (int i = 0; i < 10; i++) pt_exp.push_back(i < 8 ? e[i] : 1'b1);
    bus.nes_strobe = 1'b1;
    cycles(2);
    bus.nes_strobe = 1'b0;
    cycles(1);
    check("emu_bit0", 32'(bus.nes_data[0]), 32'(pt_exp.pop_front()));
    e = ~pad_val1;
    check("emu_pad1_bit0", 32'(bus.nes_data[1]), 32'(e[0]));
    for (int i = 1; i < 10; i++) begin
      bus.nes_clock[0] = 1'b1;
      cycles(1);
      bus.nes_clock[0] = 1'b0;
      cycles(1);
      check($sformatf("emu_bit%0d", i), 32'(bus.nes_data[0]), 32'(pt_exp.pop_front()));
    end

    pad_val0 = 8'h0F;
    pad_val1 = 8'hFF;
    exp_q.push_back({~pad_val1, ~pad_val0});
    vcnt0 = valid_cnt;
    start_poll();
    wait_ticks(20);
    bus.poll_start = 1'b1;
    bus.mode       = 1'b0;
    wait_ticks(1);
    bus.poll_start = 1'b0;
    check("mode_change_busy", 32'(bus.busy), 32'd1);
    bus.nes_strobe = 1'b1;
    #1;
    check("latched_mode_holds", 32'(bus.joy_strobe), 32'd0);
    bus.nes_strobe = 1'b0;
    wait_idle(1000);
    cycles(200);
    check("single_valid", 32'(valid_cnt - vcnt0), 32'd1);
    bus.nes_strobe = 1'b1;
    #1;
    check("passthrough_after_done", 32'(bus.joy_strobe), 32'd1);
    bus.nes_strobe = 1'b0;

    bus.mode = 1'b1;
    cycles(3);
    pad_val0 = 8'h81;
    pad_val1 = 8'h00;
    exp_q.push_back({~pad_val1, ~pad_val0});
    start_poll();
    k = 0;
    while (!bus.joy_clock[0] && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("reach_clk_hi", 32'(bus.joy_clock[0]), 32'd1);
    stall = 1'b1;
    held  = 1'b1;
    repeat (50) begin
      @(negedge clock);
      held &= bus.joy_clock[0];
    end
    stall = 1'b0;
    check("stall_clock_high", 32'(held), 32'd1);
    wait_idle(2000);
    check("stall_len", 32'(last_len), 32'd410);

    pad_val0 = 8'h00;
    vcnt0 = valid_cnt;
    start_poll();
    wait_ticks(40);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_strobe", 32'(bus.joy_strobe), 32'd0);
    check("mid_rst_buttons", 32'(bus.buttons), 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(500);
    check("no_valid_after_rst", 32'(valid_cnt - vcnt0), 32'd0);
    check("post_rst_buttons", 32'(bus.buttons), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size() + pt_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
